// File: rtl/axi_lite_sram_model.sv
// AXI4-Lite word-addressed SRAM slave model with programmable response latency.
// One outstanding transaction at a time; a read wins over a simultaneous write.
// Optional feature macro: AXI_LITE_SRAM_RAND_DELAY_EN. When defined, response latency
// comes from a 4-bit LFSR (1..4 cycles) and LATENCY is ignored.
module axi_lite_sram_model #(
    parameter string       HEX_FILE  = "none",
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 32768,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    // Read address / data channels
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    // Write address / data / response channels
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [32:0] ADDR_SPAN = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_DEC  = 2'b11;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdWait = 3'd1,
        StRdResp = 3'd2,
        StWrWait = 3'd3,
        StWrResp = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [3:0]  w_lat_m1;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_bvalid;
    logic [1:0]  r_bresp;

    logic        w_ar_hs;
    logic        w_aw_hs;
    logic [31:0] w_off;
    logic        w_in_range;
    logic [IDX_W-1:0] w_index;
    logic        w_rd_present;
    logic        w_wr_commit;

    logic [31:0] r_mem [DEPTH];

    // Parameter sanity at time 0.
    initial begin
`ifndef AXI_LITE_SRAM_RAND_DELAY_EN
        if (LATENCY < 1 || LATENCY > 15) begin
            $fatal(1, "axi_lite_sram_model: LATENCY %0d outside 1..15", LATENCY);
        end
`endif
        if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin
            $fatal(1, "axi_lite_sram_model: DEPTH %0d is not a power of two", DEPTH);
        end
    end

    // Address decode on the latched address; subtraction wraps so addresses
    // below BASE_ADDR land far above the span and decode as out of range.
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_off} < ADDR_SPAN);
    assign w_index    = w_off[IDX_W+1:2];

    // First cycle in a response state is when data is fetched / write is committed.
    assign w_rd_present = (r_state == StRdResp) && !r_rvalid;
    assign w_wr_commit  = (r_state == StWrResp) && !r_bvalid;

`ifdef AXI_LITE_SRAM_RAND_DELAY_EN
    logic [3:0] r_lfsr;

    // Fibonacci LFSR x^4+x^3+1, advanced once per accepted request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= 4'b1001;
        end else if (w_ar_hs || w_aw_hs) begin
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        end
    end

    assign w_lat_m1 = {2'b00, r_lfsr[1:0]};
`else
    assign w_lat_m1 = LAT_M1;
`endif

    // State and latency counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, counter and ready decode; reads take priority over writes.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        arready      = 1'b0;
        awready      = 1'b0;
        wready       = 1'b0;
        w_ar_hs      = 1'b0;
        w_aw_hs      = 1'b0;
        unique case (r_state)
            StIdle: begin
                arready = 1'b1;
                awready = awvalid && wvalid && !arvalid;
                wready  = awvalid && wvalid && !arvalid;
                if (arvalid) begin
                    w_ar_hs      = 1'b1;
                    w_cnt_next   = w_lat_m1;
                    w_state_next = (w_lat_m1 == 4'd0) ? StRdResp : StRdWait;
                end else if (awvalid && wvalid) begin
                    w_aw_hs      = 1'b1;
                    w_cnt_next   = w_lat_m1;
                    w_state_next = (w_lat_m1 == 4'd0) ? StWrResp : StWrWait;
                end
            end
            StRdWait: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = StRdResp;
                end
            end
            StRdResp: begin
                if (r_rvalid && rready) begin
                    w_state_next = StIdle;
                end
            end
            StWrWait: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = StWrResp;
                end
            end
            StWrResp: begin
                if (r_bvalid && bready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Request capture and response channel registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= RESP_OKAY;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_addr <= araddr;
            end else if (w_aw_hs) begin
                r_addr  <= awaddr;
                r_wdata <= wdata;
                r_wstrb <= wstrb;
            end

            if (w_rd_present) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_in_range ? r_mem[w_index] : 32'd0;
                r_rresp  <= w_in_range ? RESP_OKAY : RESP_DEC;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end

            if (w_wr_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_in_range ? RESP_OKAY : RESP_DEC;
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Byte-masked write into the array; the array itself is never reset.
    always_ff @(posedge clock) begin
        if (w_wr_commit && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) begin
                    r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign rresp  = r_rresp;
    assign bvalid = r_bvalid;
    assign bresp  = r_bresp;

endmodule

// File: tb/tb_axi_lite_sram_model.sv
// Self-checking bench for axi_lite_sram_model (default build, LATENCY = 2).
// Expected read data/resp and write resp are queued when a request is driven and
// compared when the DUT presents the response.
module tb_axi_lite_sram_model;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          LAT  = 2;

    logic        clock;
    logic        reset;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    int n_checks;
    int n_errors;

    logic [33:0] rd_q[$];
    logic [1:0]  wr_q[$];

    axi_lite_sram_model #(
        .HEX_FILE  ("none"),
        .BASE_ADDR (BASE),
        .DEPTH     (32768),
        .LATENCY   (LAT)
    ) u_dut (
        .clock   (clock),
        .reset   (reset),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Full read transaction starting at a negedge; rready held low for 'hold' cycles.
    task automatic read_txn(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold);
        int n;
        logic [33:0] exp;
        rd_q.push_back({exp_resp, exp_data});
        arvalid = 1'b1;
        araddr  = addr;
        #1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check_eq("rd_arready", 32'(arready), 32'd1);
        @(negedge clock);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_eq("rd_latency", 32'(n), 32'(LAT));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check_eq("rd_hold_rvalid", 32'(rvalid), 32'd1);
            check_eq("rd_hold_rdata", rdata, rd_q[0][31:0]);
            check_eq("rd_hold_rresp", 32'(rresp), 32'(rd_q[0][33:32]));
            check_eq("rd_hold_arready", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        if (rd_q.size() == 0) begin
            check_eq("rd_queue_empty", 32'd1, 32'd0);
        end else begin
            exp = rd_q.pop_front();
            check_eq("rd_data", rdata, exp[31:0]);
            check_eq("rd_resp", 32'(rresp), 32'(exp[33:32]));
        end
        @(negedge clock);
        rready = 1'b0;
        check_eq("rd_rvalid_drop", 32'(rvalid), 32'd0);
        check_eq("rd_back_idle", 32'(arready), 32'd1);
    endtask

    // Full write transaction starting at a negedge.
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        int n;
        wr_q.push_back(exp_resp);
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        #1;
        n = 0;
        while (!awready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check_eq("wr_awready", 32'(awready && wready), 32'd1);
        @(negedge clock);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_eq("wr_latency", 32'(n), 32'(LAT));
        bready = 1'b1;
        if (wr_q.size() == 0) begin
            check_eq("wr_queue_empty", 32'd1, 32'd0);
        end else begin
            check_eq("wr_resp", 32'(bresp), 32'(wr_q.pop_front()));
        end
        @(negedge clock);
        bready = 1'b0;
        check_eq("wr_bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] model [6];
        int n;
        n_checks = 0;
        n_errors = 0;
        reset   = 1'b1;
        arvalid = 1'b0;
        araddr  = 32'd0;
        rready  = 1'b0;
        awvalid = 1'b0;
        awaddr  = 32'd0;
        wvalid  = 1'b0;
        wdata   = 32'd0;
        wstrb   = 4'd0;
        bready  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_bvalid", 32'(bvalid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_rresp", 32'(rresp), 32'd0);
        check_eq("rst_bresp", 32'(bresp), 32'd0);
        check_eq("rst_arready", 32'(arready), 32'd1);
        reset = 1'b0;
        @(negedge clock);

        // Preload (stands in for the hex image) and basic read.
        write_txn(BASE, 32'h0000_0297, 4'hf, 2'b00);
        write_txn(BASE + 32'h10, 32'h0000_0000, 4'hf, 2'b00);
        read_txn(BASE, 32'h0000_0297, 2'b00, 0);

        // Partial strobes, then unaligned low bits ignored.
        write_txn(BASE + 32'h10, 32'hDEAD_BEEF, 4'b0101, 2'b00);
        read_txn(BASE + 32'h10, 32'h00AD_00EF, 2'b00, 0);
        read_txn(BASE + 32'h13, 32'h00AD_00EF, 2'b00, 0);

        // Range boundaries.
        read_txn(32'h7FFF_FFFC, 32'h0, 2'b11, 0);
        write_txn(32'h8002_0000, 32'h1111_1111, 4'hf, 2'b11);
        read_txn(32'h8002_0000, 32'h0, 2'b11, 0);
        write_txn(32'h8001_FFFC, 32'h1234_5678, 4'hf, 2'b00);
        read_txn(32'h8001_FFFC, 32'h1234_5678, 2'b00, 0);
        read_txn(BASE, 32'h0000_0297, 2'b00, 0);

        // Read and write offered together: read wins, write follows.
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = BASE + 32'h20;
        wdata   = 32'hCAFE_F00D;
        wstrb   = 4'hf;
        arvalid = 1'b1;
        araddr  = BASE;
        #1;
        check_eq("arb_arready", 32'(arready), 32'd1);
        check_eq("arb_awready", 32'(awready), 32'd0);
        check_eq("arb_wready", 32'(wready), 32'd0);
        read_txn(BASE, 32'h0000_0297, 2'b00, 0);
        #1;
        check_eq("arb_awready_after", 32'(awready), 32'd1);
        write_txn(BASE + 32'h20, 32'hCAFE_F00D, 4'hf, 2'b00);
        read_txn(BASE + 32'h20, 32'hCAFE_F00D, 2'b00, 0);

        // Back-pressure on R.
        read_txn(BASE + 32'h10, 32'h00AD_00EF, 2'b00, 5);

        // Asynchronous reset while waiting.
        arvalid = 1'b1;
        araddr  = BASE + 32'h10;
        @(negedge clock);
        arvalid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_wait_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_wait_arready", 32'(arready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        read_txn(BASE + 32'h10, 32'h00AD_00EF, 2'b00, 0);

        // Asynchronous reset while a response is being held.
        arvalid = 1'b1;
        araddr  = BASE;
        @(negedge clock);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_eq("rst_resp_pre", 32'(rvalid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_resp_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_resp_rdata", rdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Reset before commit drops the write.
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = BASE + 32'h10;
        wdata   = 32'hFFFF_FFFF;
        wstrb   = 4'hf;
        @(negedge clock);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_wr_bvalid", 32'(bvalid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        read_txn(BASE + 32'h10, 32'h00AD_00EF, 2'b00, 0);

        // Random data sweep.
        for (int i = 0; i < 6; i++) begin
            model[i] = $urandom;
            write_txn(BASE + 32'h200 + 32'(4 * i), model[i], 4'hf, 2'b00);
        end
        for (int i = 0; i < 6; i++) begin
            read_txn(BASE + 32'h200 + 32'(4 * i), model[i], 2'b00, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
